// File: rtl/vga_timing_pkg.sv
// Shared timing constants and axis-state encoding for the VGA raster generator.
package vga_timing_pkg;

    // Raster counters are 11 bits wide; totals above 2047 cannot be represented.
    localparam int COUNT_W = 11;

    // Default 640x480@60 timing (pixels / lines).
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Full span of one axis: visible + front porch + sync + back porch.
    function automatic int axis_total(input int vis, input int front, input int sync, input int back);
        return vis + front + sync + back;
    endfunction

    localparam int H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    // Phase of one raster axis; both axes walk VISIBLE -> FRONT -> SYNC -> BACK.
    typedef enum logic [1:0] {
        ST_VISIBLE = 2'd0,
        ST_FRONT   = 2'd1,
        ST_SYNC    = 2'd2,
        ST_BACK    = 2'd3
    } axis_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus 4-phase sync FSM, advancing on enable.
// Exposes look-ahead flags so the parent can register its outputs against the
// position that is about to be loaded, keeping every output aligned with count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VIS_LEN   = DEF_H_VISIBLE,
    parameter int FRONT_LEN = DEF_H_FRONT,
    parameter int SYNC_LEN  = DEF_H_SYNC,
    parameter int BACK_LEN  = DEF_H_BACK
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic [COUNT_W-1:0] count,
    output logic               wrap,
    output logic               sync_active,
    output logic               visible_next,
    output logic               last_next
);

    localparam int TOTAL = axis_total(VIS_LEN, FRONT_LEN, SYNC_LEN, BACK_LEN);

    // Last position of each phase; the FSM leaves a phase when count sits here.
    localparam logic [COUNT_W-1:0] VIS_END   = COUNT_W'(VIS_LEN - 1);
    localparam logic [COUNT_W-1:0] FRONT_END = COUNT_W'(VIS_LEN + FRONT_LEN - 1);
    localparam logic [COUNT_W-1:0] SYNC_END  = COUNT_W'(VIS_LEN + FRONT_LEN + SYNC_LEN - 1);
    localparam logic [COUNT_W-1:0] LAST      = COUNT_W'(TOTAL - 1);

    axis_state_t        state;
    axis_state_t        state_next;
    logic [COUNT_W-1:0] count_next;

    // Next position and phase, evaluated only when this axis is told to advance.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        count_next = count;
        state_next = state;
        wrap       = enable && (count == LAST);
        if (enable) begin
            count_next = (count == LAST) ? '0 : count + COUNT_W'(1);
            unique case (state)
                ST_VISIBLE: if (count == VIS_END)   state_next = ST_FRONT;
                ST_FRONT:   if (count == FRONT_END) state_next = ST_SYNC;
                ST_SYNC:    if (count == SYNC_END)  state_next = ST_BACK;
                ST_BACK:    if (count == LAST)      state_next = ST_VISIBLE;
            endcase
        end
        visible_next = (state_next == ST_VISIBLE);
        last_next    = (count_next == LAST);
    end

    // Position, phase and registered sync flag; reset parks the axis on its last position.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
        if (reset) begin
            count       <= LAST;
            state       <= ST_BACK;
            sync_active <= 1'b0;
        end else if (enable) begin
            count       <= count_next;
            state       <= state_next;
            sync_active <= (state_next == ST_SYNC);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel-rate prescaler, horizontal and vertical axis
// counters, sync pins and line/frame markers, all aligned to the same pixel.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int SYNC_POL  = 0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pix_en,
    output logic [COUNT_W-1:0] countH,
    output logic [COUNT_W-1:0] countV,
    output logic               h_sinc,
    output logic               v_sinc,
    output logic               visible,
    output logic               h_Disp,
    output logic               v_Disp
);

    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic              ACTIVE   = (SYNC_POL != 0);

    logic [DIV_W-1:0] divider;

    logic h_wrap;
    logic h_sync_active;
    logic h_visible_next;
    logic h_last_next;
    logic v_enable;
    logic v_sync_active;
    logic v_visible_next;
    logic v_last_next;
    logic frame_wrap_unused;   // end-of-frame is taken from the look-ahead flags instead

    // Prescaler: divider cycles 0..CLK_DIV-1, pix_en is a registered one-clock pulse on its last count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divider <= '0;
            pix_en  <= 1'b0;
        end else begin
            pix_en  <= (divider == DIV_LAST);
            divider <= (divider == DIV_LAST) ? '0 : divider + DIV_W'(1);
        end
    end

    // Lines advance only on the pixel edge that wraps the horizontal counter.
    assign v_enable = pix_en && h_wrap;

    vga_axis_counter #(
        .VIS_LEN   (H_VISIBLE),
        .FRONT_LEN (H_FRONT),
        .SYNC_LEN  (H_SYNC),
        .BACK_LEN  (H_BACK)
    ) u_h_axis (
        .clk          (clk),
        .reset        (reset),
        .enable       (pix_en),
        .count        (countH),
        .wrap         (h_wrap),
        .sync_active  (h_sync_active),
        .visible_next (h_visible_next),
        .last_next    (h_last_next)
    );

    vga_axis_counter #(
        .VIS_LEN   (V_VISIBLE),
        .FRONT_LEN (V_FRONT),
        .SYNC_LEN  (V_SYNC),
        .BACK_LEN  (V_BACK)
    ) u_v_axis (
        .clk          (clk),
        .reset        (reset),
        .enable       (v_enable),
        .count        (countV),
        .wrap         (frame_wrap_unused),
        .sync_active  (v_sync_active),
        .visible_next (v_visible_next),
        .last_next    (v_last_next)
    );

    // Visible flag and markers are registered from the upcoming position so they never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            visible <= 1'b0;
            h_Disp  <= 1'b0;
            v_Disp  <= 1'b0;
        end else if (pix_en) begin
            visible <= h_visible_next && v_visible_next;
            h_Disp  <= h_last_next;
            v_Disp  <= h_last_next && v_last_next;
        end
    end

    // Sync pins: a register steered to a constant level, so polarity adds no combinational hazard.
    assign h_sinc = h_sync_active ? ACTIVE : ~ACTIVE;
    assign v_sinc = v_sync_active ? ACTIVE : ~ACTIVE;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three instances (default, fast/active-high, small frame)
// compared every clock against an arithmetic raster model driven by the number
// of clock edges since reset release, plus line/frame-level timing checks.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    typedef struct {
        int d, hv, hf, hs, hb, vv, vf, vs, vb, pol;
    } cfg_t;

    typedef struct {
        logic pe;
        int   h;
        int   v;
        logic hs, vs, vis, hd, vd;
    } exp_t;

    // Small frame so whole frames fit in a short run.
    localparam int S_DIV = 3;
    localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VV = 6, S_VF = 2, S_VS = 2, S_VB = 3;

    // Elaboration guard: every parameter set must fit the 11-bit counters.
    if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_default
        $error("illegal default parameter set: total exceeds 2047");
    end
    if (S_HV + S_HF + S_HS + S_HB > 2047 || S_VV + S_VF + S_VS + S_VB > 2047) begin : g_bad_small
        $error("illegal small parameter set: total exceeds 2047");
    end

    logic clk = 1'b0;
    logic reset;
    longint k = 0;        // clock edges since reset release
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    logic        def_pe, def_hs, def_vs, def_vis, def_hd, def_vd;
    logic [10:0] def_h, def_v;
    logic        fst_pe, fst_hs, fst_vs, fst_vis, fst_hd, fst_vd;
    logic [10:0] fst_h, fst_v;
    logic        sm_pe, sm_hs, sm_vs, sm_vis, sm_hd, sm_vd;
    logic [10:0] sm_h, sm_v;

    vga_timing_gen dut_def (
        .clk(clk), .reset(reset), .pix_en(def_pe), .countH(def_h), .countV(def_v),
        .h_sinc(def_hs), .v_sinc(def_vs), .visible(def_vis), .h_Disp(def_hd), .v_Disp(def_vd)
    );

    vga_timing_gen #(.CLK_DIV(1), .SYNC_POL(1)) dut_fast (
        .clk(clk), .reset(reset), .pix_en(fst_pe), .countH(fst_h), .countV(fst_v),
        .h_sinc(fst_hs), .v_sinc(fst_vs), .visible(fst_vis), .h_Disp(fst_hd), .v_Disp(fst_vd)
    );

    vga_timing_gen #(
        .CLK_DIV(S_DIV),
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .SYNC_POL(0)
    ) dut_small (
        .clk(clk), .reset(reset), .pix_en(sm_pe), .countH(sm_h), .countV(sm_v),
        .h_sinc(sm_hs), .v_sinc(sm_vs), .visible(sm_vis), .h_Disp(sm_hd), .v_Disp(sm_vd)
    );

    cfg_t cfg_def, cfg_fast, cfg_small;

    // Raster reference: pixel index since release determines everything.
    function automatic exp_t model(input cfg_t c, input longint kk);
        exp_t   e;
        longint ht, vt, n, p;
        logic   pol;
        ht  = c.hv + c.hf + c.hs + c.hb;
        vt  = c.vv + c.vf + c.vs + c.vb;
        pol = (c.pol != 0);
        e.pe = (kk > 0) && (kk % c.d == 0);
        n = (kk > 0) ? (kk - 1) / c.d : 0;
        if (n == 0) begin
            e.h = int'(ht - 1);  e.v = int'(vt - 1);
            e.hs = ~pol; e.vs = ~pol;
            e.vis = 1'b0; e.hd = 1'b0; e.vd = 1'b0;
        end else begin
            p   = (n - 1) % (ht * vt);
            e.h = int'(p % ht);
            e.v = int'(p / ht);
            e.hs  = (e.h >= c.hv + c.hf && e.h < c.hv + c.hf + c.hs) ? pol : ~pol;
            e.vs  = (e.v >= c.vv + c.vf && e.v < c.vv + c.vf + c.vs) ? pol : ~pol;
            e.vis = (e.h < c.hv) && (e.v < c.vv);
            e.hd  = (e.h == ht - 1);
            e.vd  = (e.h == ht - 1) && (e.v == vt - 1);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic cmp_inst(input string nm, input cfg_t c, input logic pe,
                            input logic [10:0] h, input logic [10:0] v,
                            input logic hs, input logic vs, input logic vis,
                            input logic hd, input logic vd);
        exp_t e;
        e = model(c, k);
        chk({nm, ".pix_en"},  32'(pe),  32'(e.pe));
        chk({nm, ".countH"},  32'(h),   e.h);
        chk({nm, ".countV"},  32'(v),   e.v);
        chk({nm, ".h_sinc"},  32'(hs),  32'(e.hs));
        chk({nm, ".v_sinc"},  32'(vs),  32'(e.vs));
        chk({nm, ".visible"}, 32'(vis), 32'(e.vis));
        chk({nm, ".h_Disp"},  32'(hd),  32'(e.hd));
        chk({nm, ".v_Disp"},  32'(vd),  32'(e.vd));
    endtask

    task automatic check_all();
        cmp_inst("def",   cfg_def,   def_pe, def_h, def_v, def_hs, def_vs, def_vis, def_hd, def_vd);
        cmp_inst("fast",  cfg_fast,  fst_pe, fst_h, fst_v, fst_hs, fst_vs, fst_vis, fst_hd, fst_vd);
        cmp_inst("small", cfg_small, sm_pe,  sm_h,  sm_v,  sm_hs,  sm_vs,  sm_vis,  sm_hd,  sm_vd);
    endtask

    initial begin
        int     def_falls[$];
        int     fst_falls[$];
        logic   prev_def_hs, prev_fst_hs;
        int     sm_vis_clks, sm_vd_clks, sm_vs_clks;
        int     sm_frame_clks;
        int     f0, f1;
        int unsigned gap, hold;

        cfg_def   = '{2, DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK,
                      DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK, 0};
        cfg_fast  = '{1, DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK,
                      DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK, 1};
        cfg_small = '{S_DIV, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 0};
        sm_frame_clks = S_DIV * (S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB);

        // Step 1: hold reset for 5 clocks, outputs at reset values.
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (5) @(negedge clk);
        check_all();

        // Step 2: synchronous release, then run several lines / small frames.
        @(negedge clk);
        reset = 1'b0;
        prev_def_hs = def_hs;
        prev_fst_hs = fst_hs;
        sm_vis_clks = 0; sm_vd_clks = 0; sm_vs_clks = 0;
        for (int i = 0; i < 3200; i++) begin
            @(negedge clk);
            check_all();
            if (prev_def_hs && !def_hs) def_falls.push_back(int'(k));
            if (!prev_fst_hs && fst_hs) fst_falls.push_back(int'(k));
            prev_def_hs = def_hs;
            prev_fst_hs = fst_hs;
            // First small frame occupies edges S_DIV+1 .. S_DIV*(P+1).
            if (k >= S_DIV + 1 && k <= S_DIV + sm_frame_clks) begin
                if (sm_vis) sm_vis_clks++;
                if (sm_vd)  sm_vd_clks++;
                if (!sm_vs) sm_vs_clks++;
            end
        end

        // Line timing: first h_sinc activation at pixel 656 (edge 2*657+1), period 800 pixels.
        f0 = (def_falls.size() > 0) ? def_falls[0] : -1;
        f1 = (def_falls.size() > 1) ? def_falls[1] : -1;
        chk("def.hsync_first_edge", f0, 1315);
        chk("def.hsync_period_clks", f1 - f0, 1600);
        f0 = (fst_falls.size() > 0) ? fst_falls[0] : -1;
        f1 = (fst_falls.size() > 1) ? fst_falls[1] : -1;
        chk("fast.hsync_period_clks", f1 - f0, 800);

        // Frame-level counts on the small raster, in pixel periods.
        chk("small.visible_pixels", sm_vis_clks / S_DIV, S_HV * S_VV);
        chk("small.v_Disp_pixels",  sm_vd_clks / S_DIV, 1);
        chk("small.v_sync_pixels",  sm_vs_clks / S_DIV, S_VS * (S_HV + S_HF + S_HS + S_HB));

        // Step 3: asynchronous resets at random points between clock edges.
        for (int r = 0; r < 3; r++) begin
            gap = $urandom_range(1500, 100);
            repeat (gap) begin
                @(negedge clk);
                check_all();
            end
            #2 reset = 1'b1;
            #1 check_all();
            hold = $urandom_range(6, 2);
            repeat (hold) begin
                @(negedge clk);
                check_all();
            end
            @(negedge clk);
            reset = 1'b0;
            repeat (900) begin
                @(negedge clk);
                check_all();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
